// File: rtl/sa_tile_ctrl_pkg.sv
// rtl/sa_tile_ctrl_pkg.sv - shared state type and size helpers for the systolic tile controller
package sa_pkg;

   typedef enum logic [1:0] {IDLE, FEED, FLUSH, DRAIN} sa_state_t;

   // cycles the last operand needs to reach the far corner PE and settle there
   function automatic int flush_len(input int nr, input int nc, input int pl);
      return (nr - 1) + (nc - 1) + pl;
   endfunction

   function automatic int step_width(input int km, input int nr, input int nc, input int pl);
      return $clog2(km + nr + nc + pl);
   endfunction

endpackage

// File: rtl/sa_tile_ctrl_if.sv
// rtl/sa_tile_ctrl_if.sv - operand, array and result signals of the systolic tile controller
interface sa_tile_ctrl_if #(
   parameter int data_width = 8,
   parameter int num_row    = 8,
   parameter int num_col    = 8,
   parameter int k_max      = 64
);
   logic                              start;
   logic [$clog2(k_max+1)-1:0]        k_len;
   logic                              op_valid;
   logic                              op_ready;
   logic [num_row:1][data_width-1:0]  a_vec;
   logic [num_col:1][data_width-1:0]  b_vec;
   logic                              sa_en;
   logic [num_row:1][num_col:1]       sa_clc;
   logic [num_row:1][data_width-1:0]  sa_row_in;
   logic [num_col:1][data_width-1:0]  sa_col_in;
   logic [num_row:1]                  sa_row_out_valid;
   logic [num_col:1][data_width-1:0]  sa_row_out;
   logic                              res_valid;
   logic                              res_ready;
   logic [num_col:1][data_width-1:0]  res_data;
   logic [$clog2(num_row+1)-1:0]      res_row;
   logic                              busy;
   logic                              done;

   modport master (
      input  start, k_len, op_valid, a_vec, b_vec, sa_row_out, res_ready,
      output op_ready, sa_en, sa_clc, sa_row_in, sa_col_in, sa_row_out_valid,
             res_valid, res_data, res_row, busy, done
   );

   modport slave (
      output start, k_len, op_valid, a_vec, b_vec, sa_row_out, res_ready,
      input  op_ready, sa_en, sa_clc, sa_row_in, sa_col_in, sa_row_out_valid,
             res_valid, res_data, res_row, busy, done
   );
endinterface

// File: rtl/sa_tile_ctrl_skew_line.sv
// rtl/sa_tile_ctrl_skew_line.sv - enabled delay line for one operand lane, depth 0 is a wire
module sa_skew_line #(
   parameter int width = 8,
   parameter int depth = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [width-1:0] din,
   output logic [width-1:0] dout
);
   if (depth == 0) begin : g_wire
      logic unused_ok;
      assign unused_ok = ^{clk, rst, en};
      assign dout      = din;
   end else begin : g_chain
      logic [depth-1:0][width-1:0] q;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            q <= '0;
         end else if (en) begin
            q[0] <= din;
            for (int i = 1; i < depth; i++) q[i] <= q[i-1];
         end
      end

      assign dout = q[depth-1];
   end
endmodule

// File: rtl/sa_tile_ctrl.sv
// rtl/sa_tile_ctrl.sv - operand skew, clc scheduling and row drain for one systolic tile
module sa_tile_ctrl
   import sa_pkg::*;
#(
   parameter int data_width = 8,
   parameter int num_row    = 8,
   parameter int num_col    = 8,
   parameter int k_max      = 64,
   parameter int pe_lat     = 1
) (
   input  logic           clk,
   input  logic           rst,
   sa_tile_ctrl_if.master bus
);
   localparam int KW = $clog2(k_max + 1);
   localparam int TW = step_width(k_max, num_row, num_col, pe_lat);
   localparam int FL = flush_len(num_row, num_col, pe_lat);
   localparam int FW = (FL > 1) ? $clog2(FL) : 1;
   localparam int RW = $clog2(num_row + 1);

   sa_state_t                        state_q, state_d;
   logic [KW-1:0]                    k_len_q;
   logic [TW-1:0]                    t_q, k_last;
   logic [FW-1:0]                    flush_q;
   logic [RW-1:0]                    row_q;
   logic                             done_q, en, op_ready, accept, drain;
   logic [num_row:1][data_width-1:0] row_feed, row_in;
   logic [num_col:1][data_width-1:0] col_feed, col_in;
   logic [num_row:1][num_col:1]      clc;

   assign k_last = TW'(k_len_q) - TW'(1);
   assign accept = (state_q == FEED) && bus.op_valid;
   assign drain  = (state_q == DRAIN);

   always_comb begin
      state_d  = state_q;
      en       = 1'b0;
      op_ready = 1'b0;
      case (state_q)
         IDLE: if (bus.start && bus.k_len != '0) state_d = FEED;
         FEED: begin
            op_ready = 1'b1;
            en       = bus.op_valid;
            if (accept && t_q == k_last) state_d = (FL == 0) ? DRAIN : FLUSH;
         end
         FLUSH: begin
            en = 1'b1;
            if (flush_q == FW'(FL - 1)) state_d = DRAIN;
         end
         DRAIN: if (bus.res_ready && row_q == RW'(1)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // t only moves on enabled cycles, so stalls shift every clc strobe together
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         k_len_q <= '0;
         t_q     <= '0;
         flush_q <= '0;
         row_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= 1'b0;
         case (state_q)
            IDLE: if (bus.start) begin
               k_len_q <= bus.k_len;
               t_q     <= '0;
               flush_q <= '0;
               row_q   <= RW'(num_row);
               done_q  <= (bus.k_len == '0);
            end
            FEED, FLUSH: begin
               if (en) t_q <= t_q + TW'(1);
               if (state_q == FLUSH) flush_q <= flush_q + FW'(1);
            end
            DRAIN: if (bus.res_ready) begin
               row_q  <= row_q - RW'(1);
               done_q <= (row_q == RW'(1));
            end
            default: ;
         endcase
      end
   end

   assign row_feed = accept ? bus.a_vec : '0;
   assign col_feed = accept ? bus.b_vec : '0;

   for (genvar r = 1; r <= num_row; r++) begin : g_row
      sa_skew_line #(.width(data_width), .depth(num_row - r)) u_skew (
         .clk  (clk),
         .rst  (rst),
         .en   (en),
         .din  (row_feed[r]),
         .dout (row_in[r])
      );
      for (genvar c = 1; c <= num_col; c++) begin : g_clc
         assign clc[r][c] = en && (t_q == k_last + TW'((num_row - r) + (num_col - c) + pe_lat));
      end
   end

   for (genvar c = 1; c <= num_col; c++) begin : g_col
      sa_skew_line #(.width(data_width), .depth(num_col - c)) u_skew (
         .clk  (clk),
         .rst  (rst),
         .en   (en),
         .din  (col_feed[c]),
         .dout (col_in[c])
      );
   end

   assign bus.op_ready         = op_ready;
   assign bus.sa_en            = en;
   assign bus.sa_clc           = clc;
   assign bus.sa_row_in        = row_in;
   assign bus.sa_col_in        = col_in;
   assign bus.sa_row_out_valid = drain ? (num_row'(1) << (row_q - RW'(1))) : '0;
   assign bus.res_valid        = drain;
   assign bus.res_data         = bus.sa_row_out;
   assign bus.res_row          = drain ? row_q : '0;
   assign bus.busy             = (state_q != IDLE);
   assign bus.done             = done_q;
endmodule

// File: tb/tb_sa_tile_ctrl.sv
// tb/tb_sa_tile_ctrl.sv - directed and randomized tiles against a behavioural array model
module tb_sa_tile_ctrl;
   localparam int DW = 8;
   localparam int NR = 3;
   localparam int NC = 2;
   localparam int KM = 64;
   localparam int PL = 1;
   localparam int KW = $clog2(KM + 1);
   localparam int FL = (NR - 1) + (NC - 1) + PL;
   localparam logic [NR*DW-1:0] RMASK = {{DW{1'b0}}, {(NR-1)*DW{1'b1}}};
   localparam logic [NC*DW-1:0] CMASK = {{DW{1'b0}}, {(NC-1)*DW{1'b1}}};

   logic clk = 1'b0;
   logic rst;
   int   n_assert = 0;
   int   n_fail   = 0;

   logic [DW-1:0] am [KM][NR+1];
   logic [DW-1:0] bm [KM][NC+1];
   logic [DW-1:0] cm [NR+1][NC+1];
   int            clc_cnt [NR+1][NC+1];
   int            kcur, t_exp;

   sa_tile_ctrl_if #(.data_width(DW), .num_row(NR), .num_col(NC), .k_max(KM)) bus ();

   sa_tile_ctrl #(.data_width(DW), .num_row(NR), .num_col(NC), .k_max(KM), .pe_lat(PL)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // array stand-in: presents the selected row of the expected product matrix
   always_comb begin
      bus.sa_row_out = '0;
      for (int r = 1; r <= NR; r++)
         if (bus.sa_row_out_valid[r])
            for (int c = 1; c <= NC; c++) bus.sa_row_out[c] = cm[r][c];
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] all_outs();
      return 64'({bus.op_ready, bus.sa_en, bus.sa_clc, bus.sa_row_in, bus.sa_col_in,
                  bus.sa_row_out_valid, bus.res_valid, bus.res_row, bus.busy, bus.done});
   endfunction

   function automatic logic [NR*DW-1:0] exp_row_in(input int t);
      logic [NR:1][DW-1:0] v;
      int k;
      v = '0;
      for (int r = 1; r <= NR; r++) begin
         k = t - (NR - r);
         if (k >= 0 && k < kcur) v[r] = am[k][r];
      end
      return v;
   endfunction

   function automatic logic [NC*DW-1:0] exp_col_in(input int t);
      logic [NC:1][DW-1:0] v;
      int k;
      v = '0;
      for (int c = 1; c <= NC; c++) begin
         k = t - (NC - c);
         if (k >= 0 && k < kcur) v[c] = bm[k][c];
      end
      return v;
   endfunction

   function automatic logic [NR*NC-1:0] exp_clc(input int t, input bit en);
      logic [NR:1][NC:1] v;
      v = '0;
      for (int r = 1; r <= NR; r++)
         for (int c = 1; c <= NC; c++)
            if (en && t == kcur - 1 + (NR - r) + (NC - c) + PL) v[r][c] = 1'b1;
      return v;
   endfunction

   function automatic logic [NC*DW-1:0] exp_res(input int r);
      logic [NC:1][DW-1:0] v;
      for (int c = 1; c <= NC; c++) v[c] = cm[r][c];
      return v;
   endfunction

   task automatic chk_cycle(input bit en, input bit feeding);
      logic [NR*DW-1:0] rexp;
      logic [NC*DW-1:0] cexp;
      rexp = exp_row_in(t_exp);
      cexp = exp_col_in(t_exp);
      chk("sa_en", 64'(bus.sa_en), 64'(en));
      chk("op_ready", 64'(bus.op_ready), 64'(feeding));
      chk("busy", 64'(bus.busy), 64'(1));
      chk("res_valid_early", 64'(bus.res_valid), 64'(0));
      chk("sa_clc", 64'(bus.sa_clc), 64'(exp_clc(t_exp, en)));
      if (en) begin
         chk("sa_row_in", 64'(bus.sa_row_in), 64'(rexp));
         chk("sa_col_in", 64'(bus.sa_col_in), 64'(cexp));
      end else begin
         chk("sa_row_in_hold", 64'(bus.sa_row_in & RMASK), 64'(rexp & RMASK));
         chk("sa_col_in_hold", 64'(bus.sa_col_in & CMASK), 64'(cexp & CMASK));
      end
      for (int r = 1; r <= NR; r++)
         for (int c = 1; c <= NC; c++)
            if (bus.sa_clc[r][c]) clc_cnt[r][c]++;
   endtask

   task automatic fill_random(input int k);
      for (int kk = 0; kk < k; kk++) begin
         for (int r = 1; r <= NR; r++) am[kk][r] = DW'($urandom);
         for (int c = 1; c <= NC; c++) bm[kk][c] = DW'($urandom);
      end
   endtask

   task automatic run_tile(input int k, input int stall_at, input int stall_len,
                           input int gap_len, input bit start_in_drain, input bit abort);
      int            acc, stalled, row, cyc;
      bit            en, rdy;
      logic [DW-1:0] sum;
      kcur  = k;
      t_exp = 0;
      for (int r = 1; r <= NR; r++)
         for (int c = 1; c <= NC; c++) begin
            clc_cnt[r][c] = 0;
            sum = '0;
            for (int kk = 0; kk < k; kk++) sum = DW'(sum + am[kk][r] * bm[kk][c]);
            cm[r][c] = sum;
         end

      bus.start = 1'b1;
      bus.k_len = KW'(k);
      @(negedge clk);
      chk("start_idle", 64'(bus.busy), 64'(0));
      @(posedge clk); #1;
      bus.start = 1'b0;

      acc = 0;
      stalled = 0;
      while (acc < k) begin
         en = !(acc == stall_at && stalled < stall_len);
         bus.op_valid = en;
         for (int r = 1; r <= NR; r++) bus.a_vec[r] = en ? am[acc][r] : DW'($urandom);
         for (int c = 1; c <= NC; c++) bus.b_vec[c] = en ? bm[acc][c] : DW'($urandom);
         @(negedge clk);
         chk_cycle(en, 1'b1);
         if (en) begin
            acc++;
            t_exp++;
         end else begin
            stalled++;
         end
         @(posedge clk); #1;
      end

      for (int i = 0; i < FL; i++) begin
         if (abort && i == 1) begin
            bus.op_valid = 1'b0;
            rst = 1'b1;
            #1;
            chk("abort_outputs_zero", all_outs(), 64'(0));
            @(posedge clk); #1;
            rst = 1'b0;
            for (int j = 0; j < 3; j++) begin
               @(negedge clk);
               chk("abort_no_done", 64'(bus.done), 64'(0));
               chk("abort_idle", 64'(bus.busy), 64'(0));
               @(posedge clk); #1;
            end
            return;
         end
         bus.op_valid = 1'($urandom_range(0, 1));
         bus.a_vec    = (NR*DW)'($urandom);
         @(negedge clk);
         chk_cycle(1'b1, 1'b0);
         t_exp++;
         @(posedge clk); #1;
      end
      bus.op_valid = 1'b0;

      for (int r = 1; r <= NR; r++)
         for (int c = 1; c <= NC; c++) chk("clc_once", 64'(clc_cnt[r][c]), 64'(1));

      row = NR;
      cyc = 0;
      while (row >= 1) begin
         if (row == NR && cyc < gap_len) rdy = 1'b0;
         else rdy = (cyc > 20) || ($urandom_range(0, 3) != 0);
         bus.res_ready = rdy;
         bus.start     = start_in_drain;
         bus.k_len     = KW'($urandom_range(0, 5));
         @(negedge clk);
         chk("res_valid", 64'(bus.res_valid), 64'(1));
         chk("res_row", 64'(bus.res_row), 64'(row));
         chk("row_out_valid", 64'(bus.sa_row_out_valid), 64'(1) << (row - 1));
         chk("res_data", 64'(bus.res_data), 64'(exp_res(row)));
         chk("drain_done_low", 64'(bus.done), 64'(0));
         chk("drain_en_low", 64'(bus.sa_en), 64'(0));
         if (rdy) row--;
         cyc++;
         @(posedge clk); #1;
      end
      bus.res_ready = 1'b0;
      bus.start     = 1'b0;

      @(negedge clk);
      chk("done_pulse", 64'(bus.done), 64'(1));
      chk("done_idle", 64'(bus.busy), 64'(0));
      chk("done_res_valid", 64'(bus.res_valid), 64'(0));
      chk("done_row_sel", 64'(bus.sa_row_out_valid), 64'(0));
      @(posedge clk); #1;
      @(negedge clk);
      chk("done_single", 64'(bus.done), 64'(0));
      chk("stay_idle", 64'(bus.busy), 64'(0));
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed still running, expected finished");
      $fatal(1, "time limit");
   end

   initial begin
      rst           = 1'b1;
      bus.start     = 1'b0;
      bus.k_len     = '0;
      bus.op_valid  = 1'b0;
      bus.a_vec     = '0;
      bus.b_vec     = '0;
      bus.res_ready = 1'b0;
      @(negedge clk);
      chk("reset_outputs", all_outs(), 64'(0));
      @(posedge clk); #1;
      rst = 1'b0;

      am[0][3] = 8'd3;  am[0][2] = 8'd5;  am[0][1] = 8'd4;
      bm[0][2] = 8'd7;  bm[0][1] = 8'd2;
      run_tile(1, 99, 0, 0, 1'b0, 1'b0);

      fill_random(4);
      run_tile(4, 2, 3, 0, 1'b0, 1'b0);
      run_tile(4, 99, 0, 0, 1'b0, 1'b0);

      fill_random(3);
      run_tile(3, 99, 0, 5, 1'b0, 1'b0);

      bus.start = 1'b1;
      bus.k_len = '0;
      @(negedge clk);
      chk("k0_start_idle", 64'(bus.busy), 64'(0));
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(negedge clk);
      chk("k0_done", 64'(bus.done), 64'(1));
      chk("k0_busy", 64'(bus.busy), 64'(0));
      chk("k0_en", 64'(bus.sa_en), 64'(0));
      @(posedge clk); #1;
      @(negedge clk);
      chk("k0_done_clear", 64'(bus.done), 64'(0));
      chk("k0_busy_after", 64'(bus.busy), 64'(0));
      chk("k0_en_after", 64'(bus.sa_en), 64'(0));
      @(posedge clk); #1;

      fill_random(2);
      run_tile(2, 99, 0, 0, 1'b0, 1'b1);
      fill_random(3);
      run_tile(3, 1, 2, 1, 1'b0, 1'b0);

      fill_random(2);
      run_tile(2, 99, 0, 2, 1'b1, 1'b0);

      for (int n = 0; n < 5; n++) begin
         int k;
         k = int'($urandom_range(1, 8));
         fill_random(k);
         run_tile(k, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
